// File: rtl/zxuno_regfifo.sv
// zxuno_regfifo: two byte FIFOs (RX from a peripheral, TX to a peripheral)
// exposed to the CPU through two ZX-Uno registers. REG_DATA pushes TX on
// write and pops RX on read. REG_STAT reports flags and clears them on write.
module zxuno_regfifo #(
    parameter logic [7:0] REG_DATA   = 8'hC6,
    parameter logic [7:0] REG_STAT   = 8'hC7,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    // CPU strobe tracking
    logic rd_d;
    logic wr_d;
    logic rd_block;
    logic wr_block;
    logic rd_armed;

    logic wr_event;
    logic rd_start;
    logic rd_end;
    logic stat_wr;
    logic rx_flush;

    // RX FIFO state
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr;
    logic [DEPTH_LOG2-1:0] rx_rd_ptr;
    logic [DEPTH_LOG2:0]   rx_count;
    logic                  rx_ovf;
    logic                  rx_nonempty;
    logic                  rx_full;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_drop;

    // TX FIFO state
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr;
    logic [DEPTH_LOG2-1:0] tx_rd_ptr;
    logic [DEPTH_LOG2:0]   tx_count;
    logic                  tx_ovf;
    logic                  tx_full;
    logic                  tx_push_req;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  tx_drop;

    logic [3:0]            rx_count_sat;
    logic [7:0]            stat_byte;

    // An event needs a fresh rising strobe. The block flags stop a strobe
    // that was already high across reset from counting as a new access.
    assign wr_event    = zxuno_regwr & ~wr_d & ~wr_block;
    assign rd_start    = zxuno_regrd & ~rd_d & ~rd_block;
    assign rd_end      = ~zxuno_regrd & rd_d;
    assign stat_wr     = wr_event & (zxuno_addr == REG_STAT);
    assign tx_push_req = wr_event & (zxuno_addr == REG_DATA);
    assign rx_flush    = stat_wr & din[0];

    assign rx_nonempty = (rx_count != '0);
    assign rx_full     = (rx_count == FULL_COUNT);
    assign tx_valid    = (tx_count != '0);
    assign tx_full     = (tx_count == FULL_COUNT);

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    // A flush discards a simultaneous RX byte without counting it as an overflow.
    assign rx_pop  = rd_end & rd_armed & rx_nonempty;
    assign rx_push = rx_strobe & ~rx_flush & (~rx_full | rx_pop);
    assign rx_drop = rx_strobe & ~rx_flush & rx_full & ~rx_pop;
    assign tx_pop  = tx_valid & tx_ready;
    assign tx_push = tx_push_req & (~tx_full | tx_pop);
    assign tx_drop = tx_push_req & tx_full & ~tx_pop;

    assign tx_data = tx_mem[tx_rd_ptr];

    // Register the CPU strobes and decide at read start whether this read will pop RX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_d     <= 1'b0;
            wr_d     <= 1'b0;
            rd_block <= 1'b1;
            wr_block <= 1'b1;
            rd_armed <= 1'b0;
        end else begin
            rd_d     <= zxuno_regrd;
            wr_d     <= zxuno_regwr;
            rd_block <= rd_block & zxuno_regrd;
            wr_block <= wr_block & zxuno_regwr;
            if (rd_start) begin
                rd_armed <= (zxuno_addr == REG_DATA) && rx_nonempty;
            end else if (rd_end) begin
                rd_armed <= 1'b0;
            end
        end
    end

    // Write incoming bytes into the FIFO storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data;
        end
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= din;
        end
    end

    // RX pointers and occupancy, with flush taking priority over push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (rx_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // TX pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // Sticky overflow flags; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            if (rx_drop) begin
                rx_ovf <= 1'b1;
            end else if (stat_wr && din[5]) begin
                rx_ovf <= 1'b0;
            end
            if (tx_drop) begin
                tx_ovf <= 1'b1;
            end else if (stat_wr && din[4]) begin
                tx_ovf <= 1'b0;
            end
        end
    end

    // The status byte holds only four count bits, so the RX count saturates at 15.
    always_comb begin
        int rx_count_int;
        rx_count_int = int'(rx_count);
        rx_count_sat = (rx_count_int > 15) ? 4'd15 : 4'(rx_count_int);
        stat_byte    = {rx_nonempty, tx_full, rx_ovf, tx_ovf, rx_count_sat};
    end

    // CPU read mux and bus drive enable.
    always_comb begin
        dout = 8'h00;
        oe   = 1'b0;
        if (zxuno_addr == REG_DATA) begin
            dout = rx_nonempty ? rx_mem[rx_rd_ptr] : 8'h00;
            oe   = zxuno_regrd;
        end else if (zxuno_addr == REG_STAT) begin
            dout = stat_byte;
            oe   = zxuno_regrd;
        end
    end

endmodule
